// File: rtl/mealy_det_pkg.sv
// Shared encodings for the run-time configurable sequence detector.
// State and mode codes are visible to software through the status port.
package mealy_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    localparam logic [1:0] MODE_OVL     = 2'd0;
    localparam logic [1:0] MODE_NOVL    = 2'd1;
    localparam logic [1:0] MODE_ONESHOT = 2'd2;
    localparam logic [1:0] MODE_RSVD    = 2'd3;

    // Mode 3 is reserved and is rejected at load time.
    function automatic logic mode_legal(input logic [1:0] m);
        return m != MODE_RSVD;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment; the count holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic at_max;

    assign at_max = &cnt;

    // Count register: clear wins, then increment unless saturated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/mealy_seq_detector.sv
// Serial Mealy sequence detector with run-time pattern, length and mode.
// match is combinational; match_q, match_cnt, state and fill are registered.
module mealy_seq_detector
    import mealy_det_pkg::*;
#(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [1:0]         cfg_mode,
    input  logic               bit_valid,
    input  logic               bit_in,
    output logic               match,
    output logic               match_q,
    output logic [CNT_W-1:0]   match_cnt,
    output logic [1:0]         state,
    output logic [LEN_W-1:0]   fill
);

    // Only MAX_LEN-1 past bits are ever compared; the newest bit
    // comes straight from bit_in, so the oldest slot is not stored.
    localparam int HW = MAX_LEN - 1;
    localparam logic [LEN_W-1:0] FULL = LEN_W'(MAX_LEN);

    state_e             state_q;
    state_e             state_d;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic [1:0]         mode_q;
    logic [HW-1:0]      hist_q;
    logic [HW-1:0]      hist_d;
    logic [LEN_W-1:0]   fill_q;
    logic [LEN_W-1:0]   fill_d;
    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN-1:0] hist_sh;
    logic [MAX_LEN-1:0] len_mask;
    logic               cfg_ok;
    logic               accept;
    logic               fill_ok;
    logic               pat_hit;
    logic               match_c;

    assign state = state_q;
    assign fill  = fill_q;
    assign match = match_c;

    // Low len bits of the window select the significant pattern bits.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    // Window and compare logic; no clock in the match cone.
    always_comb begin
        hist_sh  = {hist_q, bit_in};
        pat_hit  = ((hist_sh ^ pat_q) & len_mask) == '0;
        fill_ok  = fill_q >= (len_q - LEN_W'(1));
        accept   = (state_q == ST_RUN) && bit_valid && !cfg_load;
        match_c  = accept && fill_ok && pat_hit;
        fill_inc = (fill_q == FULL) ? fill_q : fill_q + LEN_W'(1);
        cfg_ok   = (cfg_len != '0) && (cfg_len <= FULL) &&
                   mode_legal(cfg_mode);
    end

    // Next state, history and fill; a load overrides everything else.
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        if (cfg_load) begin
            state_d = cfg_ok ? ST_RUN : ST_ERR;
            hist_d  = '0;
            fill_d  = '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (accept) begin
                        hist_d = hist_sh[HW-1:0];
                        fill_d = fill_inc;
                    end
                    if (match_c) begin
                        unique case (1'b1)
                            (mode_q == MODE_NOVL): begin
                                hist_d = '0;
                                fill_d = '0;
                            end
                            (mode_q == MODE_ONESHOT): begin
                                state_d = ST_DONE;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                ST_IDLE, ST_DONE, ST_ERR: begin
                end
                default: begin
                    state_d = ST_ERR;
                end
            endcase
        end
    end

    // FSM, history and fill registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hist_q  <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
        end
    end

    // Configuration latches, written only on a load strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q  <= '0;
            len_q  <= '0;
            mode_q <= MODE_OVL;
        end else if (cfg_load) begin
            pat_q  <= cfg_pattern;
            len_q  <= cfg_len;
            mode_q <= cfg_mode;
        end
    end

    // Registered copy of the Mealy match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_c;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cfg_load),
        .inc (match_c),
        .cnt (match_cnt)
    );

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Scoreboard bench for mealy_seq_detector with hand-computed vectors.
// Driver queues expectations; a monitor pops them on each valid/load.
module tb_mealy_seq_detector;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = $clog2(MAX_LEN) + 1;

    typedef struct packed {
        logic             m;
        logic [CNT_W-1:0] cnt;
        logic [1:0]       st;
        logic [LEN_W-1:0] fill;
    } exp_t;

    logic               clk;
    logic               rst;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic [1:0]         cfg_mode;
    logic               bit_valid;
    logic               bit_in;
    logic               match;
    logic               match_q;
    logic [CNT_W-1:0]   match_cnt;
    logic [1:0]         state;
    logic [LEN_W-1:0]   fill;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    mealy_seq_detector #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_mode    (cfg_mode),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .match       (match),
        .match_q     (match_q),
        .match_cnt   (match_cnt),
        .state       (state),
        .fill        (fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #2;
        cfg_load  = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic cfg(input int pat, input int len, input int mode,
                       input int st);
        exp_t e;
        @(posedge clk);
        #2;
        cfg_load    = 1'b1;
        cfg_pattern = MAX_LEN'(pat);
        cfg_len     = LEN_W'(len);
        cfg_mode    = 2'(mode);
        bit_valid   = 1'b0;
        bit_in      = 1'b0;
        e.m = 1'b0; e.cnt = '0; e.st = 2'(st); e.fill = '0;
        exp_q.push_back(e);
    endtask

    task automatic sbit(input logic b, input logic m, input int cnt,
                        input int st, input int fl);
        exp_t e;
        @(posedge clk);
        #2;
        cfg_load  = 1'b0;
        bit_valid = 1'b1;
        bit_in    = b;
        e.m = m; e.cnt = CNT_W'(cnt); e.st = 2'(st); e.fill = LEN_W'(fl);
        exp_q.push_back(e);
    endtask

    // Monitor: match is checked mid-cycle, registered outputs after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (bit_valid || cfg_load)) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("match", int'(match), int'(e.m));
                    @(posedge clk);
                    #1;
                    chk("match_q", int'(match_q), int'(e.m));
                    chk("match_cnt", int'(match_cnt), int'(e.cnt));
                    chk("state", int'(state), int'(e.st));
                    chk("fill", int'(fill), int'(e.fill));
                end
            end
        end
    end

    initial begin
        int waited;
        rst         = 1'b1;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_mode    = '0;
        bit_valid   = 1'b0;
        bit_in      = 1'b0;
        #12;
        chk("rst_state", int'(state), 0);
        chk("rst_fill", int'(fill), 0);
        chk("rst_cnt", int'(match_cnt), 0);
        chk("rst_match_q", int'(match_q), 0);
        chk("rst_match", int'(match), 0);
        rst = 1'b0;

        // overlap, pattern 101
        cfg(5, 3, 0, 1);
        sbit(1, 0, 0, 1, 1);
        sbit(0, 0, 0, 1, 2);
        sbit(1, 1, 1, 1, 3);
        sbit(0, 0, 1, 1, 4);
        sbit(1, 1, 2, 1, 5);

        // non-overlap, pattern 101
        cfg(5, 3, 1, 1);
        sbit(1, 0, 0, 1, 1);
        sbit(0, 0, 0, 1, 2);
        sbit(1, 1, 1, 1, 0);
        sbit(0, 0, 1, 1, 1);
        sbit(1, 0, 1, 1, 2);

        // one-shot, pattern 11
        cfg(3, 2, 2, 1);
        sbit(1, 0, 0, 1, 1);
        sbit(1, 1, 1, 2, 2);
        sbit(1, 0, 1, 2, 2);
        sbit(1, 0, 1, 2, 2);
        cfg(3, 2, 2, 1);

        // illegal configurations
        cfg(1, 0, 0, 3);
        sbit(1, 0, 0, 3, 0);
        cfg(1, MAX_LEN + 1, 0, 3);
        sbit(1, 0, 0, 3, 0);
        cfg(1, 1, 3, 3);
        sbit(1, 0, 0, 3, 0);
        cfg(1, 1, 0, 1);

        // len=1 saturation, then load colliding with a bit
        sbit(1, 1, 1, 1, 1);
        sbit(1, 1, 2, 1, 2);
        sbit(1, 1, 3, 1, 3);
        sbit(1, 1, 3, 1, 4);
        sbit(1, 1, 3, 1, 5);
        sbit(1, 1, 3, 1, 6);
        cfg(1, 1, 0, 1);
        bit_valid = 1'b1;
        bit_in    = 1'b1;

        // async reset mid-stream
        cfg(5, 3, 0, 1);
        sbit(1, 0, 0, 1, 1);
        sbit(0, 0, 0, 1, 2);
        idle();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_state", int'(state), 0);
        chk("arst_fill", int'(fill), 0);
        chk("arst_match_q", int'(match_q), 0);
        chk("arst_cnt", int'(match_cnt), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        sbit(1, 0, 0, 0, 0);
        idle();

        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            @(posedge clk);
            waited++;
        end
        repeat (2) @(posedge clk);
        chk("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=hang expected=finish");
        $fatal(1, "timeout");
    end

endmodule
